// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared master state codes, controller states and timeout limit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam logic [3:0] MST_IDLE      = 4'd0;
  localparam logic [3:0] MST_SEND_STOP = 4'd1;
  localparam logic [3:0] MST_RECV_ACK  = 4'd4;
  localparam logic [3:0] MST_SEND_DATA = 4'd5;
  localparam logic [3:0] MST_RECV_DATA = 4'd6;
  localparam logic [3:0] MST_SEND_ACK  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  localparam logic [11:0] TIMEOUT_MAX = 12'hFFF;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
// ============================================================================
// Module : i2c_sync_fifo
// Brief  : Single-clock FIFO; head reads as zero while empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             push;
  logic             pop;

  assign full_o    = (cnt_q == C_FULL);
  assign empty_o   = (cnt_q == '0);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_xfer_ctrl.sv
// ============================================================================
// Module : i2c_xfer_ctrl
// Brief  : Request-driven I2C transfer sequencer with TX/RX byte FIFOs.
//          Optional watchdog enabled by macro I2C_XFER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_xfer_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDRESSLENGTH = 7,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESSLENGTH-1:0] req_addr,
  input  logic                     req_rnw,
  input  logic [3:0]               req_nbytes,
  input  logic                     tx_wr_en,
  input  logic [7:0]               tx_wr_data,
  output logic                     tx_full,
  input  logic                     rx_rd_en,
  output logic [7:0]               rx_rd_data,
  output logic                     rx_empty,
  output logic                     busy,
  output logic                     done,
  output logic                     nack_err,
  output logic                     timeout,
  output logic                     m_start,
  output logic                     m_rorw,
  output logic [ADDRESSLENGTH-1:0] m_addr,
  output logic [3:0]               m_nbytes,
  output logic [7:0]               m_data_to_slave,
  input  logic [7:0]               m_data_from_slave,
  input  logic [3:0]               m_state
);

  ctrl_state_e              state_q, state_d;
  logic [ADDRESSLENGTH-1:0] addr_q;
  logic                     rorw_q;
  logic [3:0]               nbytes_q;
  logic [3:0]               cnt_q;
  logic                     nack_q;
  logic                     timeout_q;
  logic [3:0]               mst_prev_q;
  logic                     tx_empty;
  logic                     rx_full;
  logic                     accept;
  logic                     active;
  logic                     tx_pop;
  logic                     rx_push;
  logic                     tmo_hit;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign active  = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
  assign tx_pop  = active && (mst_prev_q == MST_SEND_DATA) && (m_state == MST_RECV_ACK) && !tx_empty;
  assign rx_push = active && (mst_prev_q == MST_RECV_DATA) && (m_state == MST_SEND_ACK) && !rx_full;

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (m_data_to_slave),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (rx_push),
    .wr_data_i (m_data_from_slave),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_rd_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

`ifdef I2C_XFER_TIMEOUT_EN
  logic [11:0] tmo_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || !active) tmo_cnt_q <= '0;
    else                tmo_cnt_q <= tmo_cnt_q + 12'd1;
  end

  assign tmo_hit = active && (tmo_cnt_q == TIMEOUT_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    m_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_nbytes == 4'd0) ? ST_DONE : ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // A write waits for data; start stays up through the cycle the master reacts.
        if (tmo_hit) begin
          state_d = ST_DONE;
        end else if (!rorw_q || !tx_empty) begin
          m_start = 1'b1;
          if (m_state != MST_IDLE) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tmo_hit)                   state_d = ST_DONE;
        else if (m_state == MST_IDLE)  state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rorw_q     <= 1'b0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mst_prev_q <= MST_IDLE;
    end else begin
      state_q    <= state_d;
      mst_prev_q <= m_state;
      if (accept) begin
        addr_q    <= req_addr;
        rorw_q    <= !req_rnw;
        nbytes_q  <= req_nbytes;
        cnt_q     <= '0;
        nack_q    <= (req_nbytes == 4'd0);
        timeout_q <= 1'b0;
      end else begin
        if ((tx_pop || rx_push) && (cnt_q < nbytes_q)) cnt_q <= cnt_q + 4'd1;
        if ((state_q == ST_RUN) && (m_state == MST_SEND_STOP) && (cnt_q < nbytes_q)) nack_q <= 1'b1;
        if (tmo_hit) timeout_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign nack_err = nack_q;
  assign timeout  = timeout_q;
  assign m_rorw   = rorw_q;
  assign m_addr   = addr_q;
  assign m_nbytes = nbytes_q;

endmodule

`default_nettype wire

// File: doc/i2c_xfer_ctrl.md
I2C_XFER_CTRL -- requirements
Module: i2c_xfer_ctrl

Interface
REQ-001 Parameter ADDRESSLENGTH SHALL default to 7 and set the target address width.
REQ-002 Parameter FIFO_DEPTH SHALL default to 8 and set the entries per TX/RX FIFO (power of two).
REQ-003 Port list, clock and reset first (name  direction  width  meaning):
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction request valid.
- req_ready  out  1  controller accepts a request.
- req_addr  in  ADDRESSLENGTH  target address.
- req_rnw  in  1  1 = read, 0 = write.
- req_nbytes  in  4  byte count, 1..15.
- tx_wr_en  in  1  push a write byte.
- tx_wr_data  in  8  write byte.
- tx_full  out  1  TX FIFO full.
- rx_rd_en  in  1  pop a read byte.
- rx_rd_data  out  8  RX FIFO head.
- rx_empty  out  1  RX FIFO empty.
- busy, done, nack_err, timeout  out  1 each  status.
- m_start, m_rorw  out  1 each  master start; m_rorw 1 = write.
- m_addr  out  ADDRESSLENGTH  master slave address.
- m_nbytes  out  4  master byte count.
- m_data_to_slave  out  8  byte offered to the master.
- m_data_from_slave  in  8  byte received by the master.
- m_state  in  4  master state code (0 Idle, 1 SendStop, 4 ReciveACK, 5 SendData, 6 ReciveData, 7 SendACK).

Function
REQ-004 FSM states: IDLE, LAUNCH, RUN, DRAIN, DONE.
REQ-005 IDLE: req_ready=1; req_valid&&req_ready latches addr, rnw, nbytes -> LAUNCH on the next cycle.
REQ-006 A request with nbytes==0 SHALL be accepted, SHALL set nack_err, and SHALL go to DONE without asserting m_start.
REQ-007 A write request SHALL stay in LAUNCH until the TX FIFO is non-empty.
REQ-008 LAUNCH: m_start=1 until m_state!=0 is seen -> RUN; m_start SHALL hold for at most 1 further cycle.
REQ-009 m_data_to_slave SHALL show the TX head.
REQ-010 The TX FIFO SHALL pop on each m_state transition 5->4.
REQ-011 m_data_from_slave SHALL be pushed into the RX FIFO on each m_state transition 6->7, and only if the RX FIFO is not full; otherwise the byte is dropped.
REQ-012 Byte counter: increments on each pop or push; 4-bit, no wrap past nbytes.
REQ-013 m_state==1 with count<nbytes SHALL set nack_err.
REQ-014 m_state==0 entered from RUN -> DRAIN for 1 cycle -> DONE.
REQ-015 DONE: done=1 for exactly 1 cycle -> IDLE.
REQ-016 nack_err and timeout SHALL clear on the next request accept.
REQ-017 busy=1 in every state except IDLE.
REQ-018 tx_wr_en while full and rx_rd_en while empty SHALL be ignored; a simultaneous push and pop on one FIFO is allowed and keeps the count unchanged.

Reset
REQ-019 RST SHALL take effect at any state, including mid-transfer, and on the next edge SHALL force IDLE, flush both FIFOs, and zero all outputs except req_ready=1, rx_empty=1 and tx_full=0.

Configuration
REQ-020 I2C_XFER_TIMEOUT_EN defined: a 12-bit counter runs in LAUNCH/RUN; at 4095 it sets timeout, drops m_start and goes to DONE.
REQ-021 I2C_XFER_TIMEOUT_EN undefined: no counter is built and timeout is tied 0.

Structure
REQ-022 Package i2c_pkg SHALL hold the master state code constants, the controller state encoding, and the TIMEOUT_MAX constant.
REQ-023 Sub-module i2c_sync_fifo (8-bit, FIFO_DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-024 Write addr=0x50, nbytes=2, TX 0xA5,0x3C; model drives m_state 5->4 twice, then 1->0 -> bytes offered in order, done pulses once, nack_err=0.
REQ-025 Read nbytes=3; model supplies 0x11,0x22,0x33 at 6->7 -> RX pops 0x11,0x22,0x33, then rx_empty=1.
REQ-026 Write nbytes=3; model goes to state 1 after 1 byte -> nack_err=1, done=1, TX still holds 2 entries.
REQ-027 RST asserted while in RUN -> next cycle IDLE, FIFOs empty, m_start=0.
REQ-028 With I2C_XFER_TIMEOUT_EN, model holds m_state=0 -> timeout=1 after 4095 cycles; without the macro, stays in LAUNCH.
REQ-029 RX FIFO full plus one more 6->7 -> byte dropped, rx count stays at FIFO_DEPTH.
